nv_ram_fifo_ctrl_128x129: RTL and testbench

Sequencing controller that turns the 128-entry x 129-bit two-port RAM macro into a valid/ready FIFO.
- Owns the write/read pointers and occupancy.
- Drives the macro's write port, registered read-address port (re) and output-register enable (ore).
- Presents a full-throughput, back-pressurable read interface despite the macro's 2-cycle read latency.
- Sits between a producer and consumer pipe; the RAM macro is instantiated beside it, not inside it.

---
 rtl/nv_ram_fifo_ctrl_128x129_pkg.sv | 21 ++
 rtl/nv_ram_fifo_ctrl_128x129_rd_pipe.sv | 41 ++++
 rtl/nv_ram_fifo_ctrl_128x129.sv | 108 ++++++++++
 tb/tb_nv_ram_fifo_ctrl_128x129.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_ram_fifo_ctrl_128x129_pkg.sv
// Shared sizing constants for the 128x129 RAM FIFO controller.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package nv_ram_fifo_ctrl_128x129_pkg;

    localparam int FIFO_DEPTH    = 128;  // entries in the RAM macro
    localparam int FIFO_AW       = 7;    // RAM address width
    localparam int FIFO_DW       = 129;  // RAM word width
    localparam int FIFO_CW       = 8;    // occupancy width, holds 0..128
    localparam int FIFO_AFULL_TH = 120;  // default almost-full threshold

    // Entries committed to the FIFO but not yet issued to the RAM read port.
    function automatic logic [FIFO_CW-1:0] fifo_avail(
        input logic [FIFO_CW-1:0] count,
        input logic               s1_vld,
        input logic               s2_vld
    );
        return count - FIFO_CW'(s1_vld) - FIFO_CW'(s2_vld);
    endfunction

endpackage

// File: rtl/nv_ram_fifo_ctrl_128x129_rd_pipe.sv
// Read-side sequencer: tracks address-captured (s1) and output-register (s2) stages, drives re/ore.
// Latency: re at T, ore at T+1, rd_pvld at T+2.
// Backpressure: rd_prdy low holds s2; s1 then holds and re is suppressed so the RAM address register keeps its value.
module nv_fifo_rd_pipe
    import nv_ram_fifo_ctrl_128x129_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [FIFO_CW-1:0] count,
    input  logic               rd_prdy,
    output logic               rd_pvld,
    output logic               ram_re,
    output logic               ram_ore
);

    logic s1_vld_q, s1_vld_d;
    logic s2_vld_q, s2_vld_d;
    logic adv2;

    // Stage advance and RAM strobe generation; re only fires when s1 is empty or draining.
    always_comb begin
        adv2     = s1_vld_q & (~s2_vld_q | rd_prdy);
        ram_ore  = adv2;
        ram_re   = (fifo_avail(count, s1_vld_q, s2_vld_q) != '0) & (~s1_vld_q | adv2);
        s1_vld_d = ram_re | (s1_vld_q & ~adv2);
        s2_vld_d = adv2 | (s2_vld_q & ~rd_prdy);
        rd_pvld  = s2_vld_q;
    end

    // Stage valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
        end
    end

endmodule

// File: rtl/nv_ram_fifo_ctrl_128x129.sv
// Valid/ready FIFO controller around an external 128x129 two-port RAM with 2-cycle registered read.
// Latency: write at T gives rd_pvld at T+3 when empty; 1 entry/clk sustained.
// Backpressure: wr_prdy drops at 128 entries (no pop bypass); rd_prdy stalls the read pipe. Optional: NV_FIFO_CTRL_AFULL_EN adds wr_afull.
module nv_ram_fifo_ctrl_128x129
    import nv_ram_fifo_ctrl_128x129_pkg::*;
#(
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int WIDTH    = FIFO_DW
`ifdef NV_FIFO_CTRL_AFULL_EN
   ,parameter int AFULL_TH = FIFO_AFULL_TH
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_pvld,
    output logic               wr_prdy,
    input  logic [WIDTH-1:0]   wr_pd,
    output logic               rd_pvld,
    input  logic               rd_prdy,
    output logic [WIDTH-1:0]   rd_pd,
    output logic               ram_we,
    output logic [FIFO_AW-1:0] ram_wa,
    output logic [WIDTH-1:0]   ram_di,
    output logic               ram_re,
    output logic [FIFO_AW-1:0] ram_ra,
    output logic               ram_ore,
    input  logic [WIDTH-1:0]   ram_dout,
    input  logic [31:0]        pwrbus_ram_pd,
    output logic [31:0]        pwrbus_ram_pd_o,
`ifdef NV_FIFO_CTRL_AFULL_EN
    output logic               wr_afull,
`endif
    output logic [FIFO_CW-1:0] wr_count
);

    localparam logic [FIFO_CW-1:0] FULL_CNT = FIFO_CW'(DEPTH);

    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_CW-1:0] count_q,  count_d;
    logic               wr_fire;
    logic               rd_fire;

    nv_fifo_rd_pipe u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .count   (count_q),
        .rd_prdy (rd_prdy),
        .rd_pvld (rd_pvld),
        .ram_re  (ram_re),
        .ram_ore (ram_ore)
    );

    // Write acceptance, pointer advance and occupancy; slots free only on pop so in-flight reads stay safe.
    always_comb begin
        wr_prdy = (count_q != FULL_CNT);
        wr_fire = wr_pvld & wr_prdy;
        rd_fire = rd_pvld & rd_prdy;
        wr_ptr_d = wr_ptr_q + FIFO_AW'(wr_fire);
        rd_ptr_d = rd_ptr_q + FIFO_AW'(ram_re);
        count_d  = count_q;
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ram_we          = wr_fire;
        ram_wa          = wr_ptr_q;
        ram_di          = wr_pd;
        ram_ra          = rd_ptr_q;
        rd_pd           = ram_dout;
        pwrbus_ram_pd_o = pwrbus_ram_pd;
        wr_count        = count_q;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef NV_FIFO_CTRL_AFULL_EN
    logic wr_afull_q, wr_afull_d;

    // Almost-full flag registered from next occupancy so it lines up with count_q.
    always_comb begin
        wr_afull_d = (count_d >= FIFO_CW'(AFULL_TH));
        wr_afull   = wr_afull_q;
    end

    // Almost-full register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_afull_q <= 1'b0;
        end else begin
            wr_afull_q <= wr_afull_d;
        end
    end
`endif

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_128x129.sv
// Bench for the 128x129 RAM FIFO controller with a behavioural RAM beside it.
// Latency: n/a.
// Backpressure: rd_prdy driven directed and random.
module tb_nv_ram_fifo_ctrl_128x129;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_pvld;
    logic         wr_prdy;
    logic [128:0] wr_pd;
    logic         rd_pvld;
    logic         rd_prdy;
    logic [128:0] rd_pd;
    logic         ram_we;
    logic [6:0]   ram_wa;
    logic [128:0] ram_di;
    logic         ram_re;
    logic [6:0]   ram_ra;
    logic         ram_ore;
    logic [128:0] ram_dout;
    logic [31:0]  pwrbus_ram_pd;
    logic [31:0]  pwrbus_ram_pd_o;
    logic [7:0]   wr_count;
`ifdef NV_FIFO_CTRL_AFULL_EN
    logic         wr_afull;
`endif

    always #5 clk = ~clk;

    nv_ram_fifo_ctrl_128x129 dut (
        .clk             (clk),
        .rst             (rst),
        .wr_pvld         (wr_pvld),
        .wr_prdy         (wr_prdy),
        .wr_pd           (wr_pd),
        .rd_pvld         (rd_pvld),
        .rd_prdy         (rd_prdy),
        .rd_pd           (rd_pd),
        .ram_we          (ram_we),
        .ram_wa          (ram_wa),
        .ram_di          (ram_di),
        .ram_re          (ram_re),
        .ram_ra          (ram_ra),
        .ram_ore         (ram_ore),
        .ram_dout        (ram_dout),
        .pwrbus_ram_pd   (pwrbus_ram_pd),
        .pwrbus_ram_pd_o (pwrbus_ram_pd_o),
`ifdef NV_FIFO_CTRL_AFULL_EN
        .wr_afull        (wr_afull),
`endif
        .wr_count        (wr_count)
    );

    // RAM macro: registered read address on re, output register loaded on ore.
    logic [128:0] mem [0:127];
    logic [6:0]   ra_q;
    logic [128:0] dout_q;
    always @(posedge clk) begin
        if (ram_we)  mem[ram_wa] <= ram_di;
        if (ram_re)  ra_q        <= ram_ra;
        if (ram_ore) dout_q      <= mem[ra_q];
    end
    assign ram_dout = dout_q;

    // Reference model: queue of committed words plus counts of reads in flight.
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc   = 0;
    logic [128:0] q [$];
    int           issued = 0;   // re seen, ore not yet
    int           loaded = 0;   // ore seen, not yet popped
    logic [6:0]   wptr = '0;
    logic [6:0]   rptr = '0;
    int           pops = 0;
    int           first_pop = -1;
    int           last_pop  = -1;

    task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [128:0] rnd129();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[128:0];
    endfunction

    // Checks the current cycle against the model, commits the model, and steps to the next cycle.
    task automatic finish_cycle();
        logic exp_prdy;
        logic wf;
        logic pop;
        chk("pwrbus", {97'd0, pwrbus_ram_pd_o}, {97'd0, pwrbus_ram_pd});
        if (rst) begin
            q.delete();
            issued = 0;
            loaded = 0;
            wptr   = '0;
            rptr   = '0;
        end else begin
            exp_prdy = (q.size() != 128);
            chk("wr_prdy",  {128'd0, wr_prdy}, {128'd0, exp_prdy});
            chk("wr_count", {121'd0, wr_count}, 129'(q.size()));
            chk("rd_pvld",  {128'd0, rd_pvld}, {128'd0, loaded != 0});
            chk("ram_we",   {128'd0, ram_we}, {128'd0, wr_pvld & exp_prdy});
`ifdef NV_FIFO_CTRL_AFULL_EN
            chk("wr_afull", {128'd0, wr_afull}, {128'd0, q.size() >= 120});
`endif
            chk("re_while_s1_stalled", {128'd0, ram_re & (issued != 0) & ~ram_ore}, 129'd0);
            chk("re_with_nothing_to_issue", {128'd0, ram_re & (q.size() == issued + loaded)}, 129'd0);
            chk("ore_without_addr", {128'd0, ram_ore & (issued == 0)}, 129'd0);
            wf  = wr_pvld & exp_prdy;
            pop = rd_pvld & rd_prdy;
            chk("ore_overwrites_unpopped", {128'd0, ram_ore & (loaded != 0) & ~pop}, 129'd0);
            if (ram_we) begin
                chk("ram_wa", {122'd0, ram_wa}, {122'd0, wptr});
                chk("ram_di", ram_di, wr_pd);
            end
            if (ram_re) chk("ram_ra", {122'd0, ram_ra}, {122'd0, rptr});
            if (pop && q.size() != 0) begin
                chk("rd_pd", rd_pd, q[0]);
                void'(q.pop_front());
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            if (pop)     loaded--;
            if (ram_ore) begin issued--; loaded++; end
            if (ram_re)  begin issued++; rptr++; end
            if (wf)      begin q.push_back(wr_pd); wptr++; end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        finish_cycle();
    endtask

    localparam logic [128:0] MAGIC = 129'h1_DEADBEEF_0123456789ABCDEF_DEADBEEF;

    initial begin
        int start_cyc;
        int p0;
        rst = 1'b1;
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        wr_pd = '0;
        pwrbus_ram_pd = 32'hA5C3_0F1E;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_wr_prdy",  {128'd0, wr_prdy}, 129'd1);
        chk("rst_rd_pvld",  {128'd0, rd_pvld}, 129'd0);
        chk("rst_wr_count", {121'd0, wr_count}, 129'd0);
        chk("rst_re_ore",   {127'd0, ram_re, ram_ore}, 129'd0);
        chk("rst_ra_wa",    {115'd0, ram_ra, ram_wa}, 129'd0);
        finish_cycle();

        // Single write: re at T+1, ore at T+2, valid at T+3
        wr_pvld = 1'b1; wr_pd = MAGIC; rd_prdy = 1'b1;
        @(negedge clk);
        chk("t0_we", {128'd0, ram_we}, 129'd1);
        finish_cycle();
        wr_pvld = 1'b0;
        @(negedge clk);
        chk("t1_re_ore", {127'd0, ram_re, ram_ore}, 129'b10);
        finish_cycle();
        @(negedge clk);
        chk("t2_re_ore", {127'd0, ram_re, ram_ore}, 129'b01);
        finish_cycle();
        @(negedge clk);
        chk("t3_pvld",  {128'd0, rd_pvld}, 129'd1);
        chk("t3_pd",    rd_pd, MAGIC);
        chk("t3_count", {121'd0, wr_count}, 129'd1);
        finish_cycle();
        @(negedge clk);
        chk("t4_count", {121'd0, wr_count}, 129'd0);
        finish_cycle();

        // Streaming 300 words across pointer wrap
        rd_prdy = 1'b1;
        start_cyc = cyc; first_pop = -1; p0 = pops;
        for (int i = 0; i < 300; i++) begin
            wr_pvld = 1'b1;
            wr_pd = 129'(i + 1000);
            tick();
        end
        wr_pvld = 1'b0;
        repeat (6) tick();
        chk("stream_pops",    129'(pops - p0), 129'd300);
        chk("stream_latency", 129'(first_pop - start_cyc), 129'd3);
        chk("stream_rate",    129'(last_pop - first_pop), 129'd299);

        // Fill to full with the consumer stalled
        rd_prdy = 1'b0;
        for (int i = 0; i < 130; i++) begin
            wr_pvld = 1'b1;
            wr_pd = rnd129();
            tick();
        end
        @(negedge clk);
        chk("full_prdy",  {128'd0, wr_prdy}, 129'd0);
        chk("full_count", {121'd0, wr_count}, 129'd128);
        finish_cycle();
        rd_prdy = 1'b1;
        @(negedge clk);
        chk("full_pop_no_bypass", {128'd0, wr_prdy}, 129'd0);
        chk("full_pop_pvld",      {128'd0, rd_pvld}, 129'd1);
        finish_cycle();
        rd_prdy = 1'b0;
        @(negedge clk);
        chk("after_pop_prdy",  {128'd0, wr_prdy}, 129'd1);
        chk("after_pop_count", {121'd0, wr_count}, 129'd127);
        finish_cycle();
        wr_pvld = 1'b0; rd_prdy = 1'b1;
        for (int k = 0; k < 400 && q.size() != 0; k++) tick();
        repeat (3) tick();
        chk("fill_drained", {121'd0, wr_count}, 129'd0);

        // Random traffic with random consumer stalls
        for (int i = 0; i < 3000; i++) begin
            wr_pvld = ($urandom_range(3, 0) != 0);
            wr_pd   = rnd129();
            rd_prdy = $urandom_range(1, 0) != 0;
            tick();
        end
        wr_pvld = 1'b0; rd_prdy = 1'b1;
        for (int k = 0; k < 400 && q.size() != 0; k++) tick();
        repeat (3) tick();
        chk("rand_drained", {121'd0, wr_count}, 129'd0);

        // Reset with five entries in flight and both stages full
        rd_prdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_pvld = 1'b1;
            wr_pd = rnd129();
            tick();
        end
        wr_pvld = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("pre_rst_pvld",  {128'd0, rd_pvld}, 129'd1);
        chk("pre_rst_count", {121'd0, wr_count}, 129'd5);
        finish_cycle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_pvld",  {128'd0, rd_pvld}, 129'd0);
        chk("post_rst_count", {121'd0, wr_count}, 129'd0);
        chk("post_rst_prdy",  {128'd0, wr_prdy}, 129'd1);
        finish_cycle();
        p0 = pops;
        wr_pvld = 1'b1; wr_pd = ~MAGIC; rd_prdy = 1'b1;
        tick();
        wr_pvld = 1'b0;
        repeat (8) tick();
        chk("post_rst_one_pop", 129'(pops - p0), 129'd1);
        chk("post_rst_empty",   {121'd0, wr_count}, 129'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
